pipeline_hazard_scoreboard: RTL and testbench

Parametrised hazard unit for the in-order pipelined core. It replaces the fixed-depth, stall-only hazard check with a shift-register scoreboard of in-flight destination registers, and adds operand forwarding, load-use stall, branch squash and a stall performance counter. It sits beside the issue register. It drives the issue-register enable, bubble insertion and the operand-select muxes in front of the execute stage.

---
 rtl/pipeline_hazard_scoreboard_pkg.sv | 25 ++
 rtl/pipeline_hazard_scoreboard_match.sv | 39 +++
 rtl/pipeline_hazard_scoreboard.sv | 78 +++++++
 tb/tb_pipeline_hazard_scoreboard.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_scoreboard_pkg.sv
// rtl/pipeline_hazard_scoreboard_pkg.sv - shared types and constants for the hazard scoreboard
package pipeline_hazard_scoreboard_pkg;

    // Entry fields are sized for the widest supported configuration; the top checks its parameters fit.
    localparam int SB_AW    = 8;
    localparam int SB_IDX_W = 4;

    localparam logic [31:0] STALL_COUNT_MAX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic                valid;
        logic [SB_AW-1:0]    dst;
        logic [SB_IDX_W-1:0] ready_idx;
    } sb_entry_t;

    function automatic int stage_idx_w(input int stages);
        int w;
        w = 1;
        for (int k = 1; k < 32; k++) begin
            if ((1 << w) < stages) w = k + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pipeline_hazard_scoreboard_match.sv
// rtl/pipeline_hazard_scoreboard_match.sv - youngest-match priority search for one source operand
module scoreboard_match
    import pipeline_hazard_scoreboard_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int REG_AW = 5,
    parameter int DATA_W = 32
) (
    input  logic                       en,
    input  logic [REG_AW-1:0]          src,
    input  sb_entry_t [STAGES-1:0]     entries,
    input  logic [STAGES*DATA_W-1:0]   stage_result,
    output logic                       hit,
    output logic                       pending,
    output logic [DATA_W-1:0]          data
);

    logic              found;
    logic              ready;
    logic [DATA_W-1:0] sel;

    // Scan oldest to youngest so the lowest matching index overwrites any older match.
    always_comb begin
        found = 1'b0;
        ready = 1'b0;
        sel   = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (entries[i].valid && entries[i].dst == SB_AW'(src)) begin
                found = 1'b1;
                ready = SB_IDX_W'(i) >= entries[i].ready_idx;
                sel   = stage_result[i*DATA_W +: DATA_W];
            end
        end
        hit     = en & found & ready;
        pending = en & found & ~ready;
        data    = hit ? sel : '0;
    end

endmodule

// File: rtl/pipeline_hazard_scoreboard.sv
// rtl/pipeline_hazard_scoreboard.sv - in-flight destination scoreboard with forwarding, stall and flush
module pipeline_hazard_scoreboard
    import pipeline_hazard_scoreboard_pkg::*;
#(
    parameter int STAGES      = 3,
    parameter int REG_AW      = 5,
    parameter int DATA_W      = 32,
    parameter int ALU_READY   = 1,
    parameter int LOAD_READY  = 2,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic                     issue_we,
    input  logic [REG_AW-1:0]        issue_dst,
    input  logic                     issue_is_load,
    input  logic                     src0_en,
    input  logic                     src1_en,
    input  logic [REG_AW-1:0]        src0,
    input  logic [REG_AW-1:0]        src1,
    input  logic [STAGES*DATA_W-1:0] stage_result,
    input  logic                     flush,
    output logic                     stall,
    output logic                     fwd0_hit,
    output logic                     fwd1_hit,
    output logic [DATA_W-1:0]        fwd0_data,
    output logic [DATA_W-1:0]        fwd1_data,
    output logic [31:0]              stall_count
);

    if (LOAD_READY >= STAGES || ALU_READY > LOAD_READY || REG_AW > SB_AW ||
        stage_idx_w(STAGES) > SB_IDX_W) begin : g_bad_params
        $error("pipeline_hazard_scoreboard: unsupported parameter combination");
    end

    sb_entry_t [STAGES-1:0] entries;
    sb_entry_t              issue_entry;
    logic                   pend0;
    logic                   pend1;
    logic                   load_issue;

    scoreboard_match #(.STAGES(STAGES), .REG_AW(REG_AW), .DATA_W(DATA_W)) u_match0 (
        .en(src0_en), .src(src0), .entries(entries), .stage_result(stage_result),
        .hit(fwd0_hit), .pending(pend0), .data(fwd0_data)
    );

    scoreboard_match #(.STAGES(STAGES), .REG_AW(REG_AW), .DATA_W(DATA_W)) u_match1 (
        .en(src1_en), .src(src1), .entries(entries), .stage_result(stage_result),
        .hit(fwd1_hit), .pending(pend1), .data(fwd1_data)
    );

    assign stall      = issue_valid & ~flush & (pend0 | pend1);
    assign load_issue = issue_valid & issue_we & ~stall & ~flush;

    always_comb begin
        issue_entry           = '0;
        issue_entry.valid     = 1'b1;
        issue_entry.dst       = SB_AW'(issue_dst);
        issue_entry.ready_idx = issue_is_load ? SB_IDX_W'(LOAD_READY) : SB_IDX_W'(ALU_READY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entries     <= '0;
            stall_count <= '0;
        end else begin
            // A flush kills the youngest entries before they move on.
            for (int i = 1; i < STAGES; i++) begin
                entries[i] <= entries[i-1];
                if (flush && (i - 1) < FLUSH_DEPTH) entries[i].valid <= 1'b0;
            end
            entries[0] <= load_issue ? issue_entry : '0;
            if (stall && stall_count != STALL_COUNT_MAX) stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// tb/tb_pipeline_hazard_scoreboard.sv - directed self-checking bench for pipeline_hazard_scoreboard
module tb_pipeline_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_we = 1'b0;
    logic [4:0]  issue_dst = '0;
    logic        issue_is_load = 1'b0;
    logic        src0_en = 1'b0;
    logic        src1_en = 1'b0;
    logic [4:0]  src0 = '0;
    logic [4:0]  src1 = '0;
    logic [95:0] stage_result = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    logic        flush = 1'b0;
    logic        stall;
    logic        fwd0_hit;
    logic        fwd1_hit;
    logic [31:0] fwd0_data;
    logic [31:0] fwd1_data;
    logic [31:0] stall_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_scoreboard dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_dst(issue_dst), .issue_is_load(issue_is_load), .src0_en(src0_en),
        .src1_en(src1_en), .src0(src0), .src1(src1), .stage_result(stage_result),
        .flush(flush), .stall(stall), .fwd0_hit(fwd0_hit), .fwd1_hit(fwd1_hit),
        .fwd0_data(fwd0_data), .fwd1_data(fwd1_data), .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] dst, input logic ld,
                         input logic e0, input logic [4:0] s0, input logic e1, input logic [4:0] s1,
                         input logic fl);
        issue_valid = v; issue_we = we; issue_dst = dst; issue_is_load = ld;
        src0_en = e0; src0 = s0; src1_en = e1; src1 = s1; flush = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        drive(1, 0, 5'd0, 0, 1, 5'd3, 1, 5'd4, 0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_hits", {30'd0, fwd0_hit, fwd1_hit}, 32'd0);
        check("reset_count", stall_count, 32'd0);
        idle();
        rst = 1'b1;
        @(negedge clk);

        // ALU producer r3, consumer on src0
        drive(1, 1, 5'd3, 0, 0, 5'd0, 0, 5'd0, 0);
        step();
        drive(1, 1, 5'd10, 0, 1, 5'd3, 0, 5'd0, 0);
        check("alu_use_stall", {31'd0, stall}, 32'd1);
        check("alu_use_nohit", {31'd0, fwd0_hit}, 32'd0);
        step();
        #1;
        check("alu_use_released", {31'd0, stall}, 32'd0);
        check("alu_fwd0_hit", {31'd0, fwd0_hit}, 32'd1);
        check("alu_fwd0_data", fwd0_data, 32'hBBBB_0001);
        check("alu_count", stall_count, 32'd1);
        step();
        idle();

        // Load producer r5, consumer on src1
        drive(1, 1, 5'd5, 1, 0, 5'd0, 0, 5'd0, 0);
        step();
        drive(1, 0, 5'd0, 0, 0, 5'd0, 1, 5'd5, 0);
        check("load_use_stall1", {31'd0, stall}, 32'd1);
        step();
        #1;
        check("load_use_stall2", {31'd0, stall}, 32'd1);
        step();
        #1;
        check("load_use_released", {31'd0, stall}, 32'd0);
        check("load_fwd1_hit", {31'd0, fwd1_hit}, 32'd1);
        check("load_fwd1_data", fwd1_data, 32'hCCCC_0002);
        check("load_count", stall_count, 32'd3);
        step();
        idle();

        // r7 in entries 0 (not ready) and 2 (ready): youngest wins
        drive(1, 1, 5'd7, 0, 0, 5'd0, 0, 5'd0, 0);
        step();
        drive(1, 1, 5'd1, 0, 0, 5'd0, 0, 5'd0, 0);
        step();
        drive(1, 1, 5'd7, 0, 0, 5'd0, 0, 5'd0, 0);
        step();
        drive(1, 0, 5'd0, 0, 1, 5'd7, 0, 5'd0, 0);
        check("youngest_stall", {31'd0, stall}, 32'd1);
        check("youngest_nohit", {31'd0, fwd0_hit}, 32'd0);
        check("youngest_nodata", fwd0_data, 32'd0);

        // Same dependent instruction with flush: flush wins
        drive(1, 1, 5'd9, 0, 1, 5'd7, 0, 5'd0, 1);
        check("flush_stall", {31'd0, stall}, 32'd0);
        step();
        drive(1, 0, 5'd0, 0, 1, 5'd7, 1, 5'd1, 0);
        check("flush_killed_r7", {31'd0, stall}, 32'd0);
        check("flush_r7_nohit", {31'd0, fwd0_hit}, 32'd0);
        check("flush_r1_fwd", fwd1_data, 32'hCCCC_0002);
        drive(1, 0, 5'd0, 0, 1, 5'd9, 0, 5'd0, 0);
        check("flush_bubble", {31'd0, fwd0_hit, stall}, 32'd0);
        check("flush_count", stall_count, 32'd3);
        idle();

        // Reset mid-stream with three valid entries
        drive(1, 1, 5'd1, 0, 0, 5'd0, 0, 5'd0, 0);
        step();
        drive(1, 1, 5'd2, 0, 0, 5'd0, 0, 5'd0, 0);
        step();
        drive(1, 1, 5'd3, 0, 0, 5'd0, 0, 5'd0, 0);
        step();
        drive(1, 0, 5'd0, 0, 1, 5'd3, 1, 5'd2, 0);
        check("prereset_stall", {31'd0, stall}, 32'd1);
        check("prereset_fwd1", fwd1_data, 32'hBBBB_0001);
        rst = 1'b0;
        #1;
        check("midreset_stall", {31'd0, stall}, 32'd0);
        check("midreset_hits", {30'd0, fwd0_hit, fwd1_hit}, 32'd0);
        check("midreset_data", fwd0_data | fwd1_data, 32'd0);
        check("midreset_count", stall_count, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1, 5'd3, 0, 1, 5'd3, 0, 5'd0, 0);
        check("postreset_stall", {31'd0, stall}, 32'd0);
        step();
        idle();

        // Counter saturation with a preloaded count
        drive(1, 1, 5'd4, 1, 0, 5'd0, 0, 5'd0, 0);
        step();
        drive(1, 0, 5'd0, 0, 1, 5'd4, 0, 5'd0, 0);
        force dut.stall_count = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count;
        step();
        #1;
        check("sat_reach", stall_count, 32'hFFFF_FFFF);
        check("sat_still_stalling", {31'd0, stall}, 32'd1);
        step();
        #1;
        check("sat_hold", stall_count, 32'hFFFF_FFFF);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
